// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto one fixed-latency memory port, data first.
module mem_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ready_o,
    output logic        stall_f_o,
    output logic        stall_m_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
    localparam logic [3:0] LAT = 4'(LATENCY);
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d, en_q, en_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    // The memory-side registers double as the request capture, so mem_en is high exactly in ISSUE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        en_d    = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (d_req_i) begin
                    owner_d = 1'b1;
                    we_d    = d_we_i;
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                    en_d    = 1'b1;
                    state_d = ISSUE;
                end else if (if_req_i) begin
                    owner_d = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                    en_d    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = mem_rdata_i;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign mem_en_o    = en_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_ready_o  = (state_q == DONE) && !owner_q;
    assign d_ready_o   = (state_q == DONE) && owner_q;
    assign if_rdata_o  = rdata_q;
    assign d_rdata_o   = rdata_q;
    assign stall_f_o   = if_req_i & ~if_ready_o;
    assign stall_m_o   = d_req_i & ~d_ready_o;
endmodule
